apb_stat_regs: RTL

APB_STAT_REGS -- requirements
Module: apb_stat_regs

---
 rtl/apb_stat_regs.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/apb_stat_regs.sv
// APB slave holding per-channel peak statistics, sticky threshold status and an irq.
// Ports: FCLK_CLK1/rstn, APB_M_0_* slave bus, StartColl/Irq, ChMaxData/ChMaxCount/ChValid.
module apb_stat_regs #(
  parameter int DATA_SIZE   = 4,
  parameter int LENGTH_ADD  = 5,
  parameter int NUM_CH      = 3,
  parameter int WAIT_STATES = 0
) (
  input  logic                            FCLK_CLK1,
  input  logic                            rstn,
  input  logic [31:0]                     APB_M_0_paddr,
  input  logic                            APB_M_0_psel,
  input  logic                            APB_M_0_penable,
  input  logic                            APB_M_0_pwrite,
  input  logic [31:0]                     APB_M_0_pwdata,
  output logic [31:0]                     APB_M_0_prdata,
  output logic                            APB_M_0_pready,
  output logic                            APB_M_0_pslverr,
  output logic                            StartColl,
  output logic                            Irq,
  input  logic [NUM_CH*DATA_SIZE-1:0]     ChMaxData,
  input  logic [NUM_CH*LENGTH_ADD-1:0]    ChMaxCount,
  input  logic [NUM_CH-1:0]               ChValid
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [1:0]            wcnt_q, wcnt_d;
  logic [7:0]            addr_q;
  logic [31:0]           wdata_q;
  logic                  write_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic                  start_q, start_d;
  logic                  irqen_q, irqen_d;
  logic [LENGTH_ADD-1:0] thresh_q, thresh_d;
  logic [NUM_CH-1:0]     status_q, status_d;
  logic                  irq_q;
  logic [LENGTH_ADD-1:0] pcnt_q [NUM_CH];
  logic [LENGTH_ADD-1:0] pcnt_d [NUM_CH];
  logic [DATA_SIZE-1:0]  pdat_q [NUM_CH];
  logic [DATA_SIZE-1:0]  pdat_d [NUM_CH];

  logic                  start_xfer;
  logic                  enter_resp;
  logic                  commit;
  logic [7:0]            rd_addr;
  logic                  rd_write;
  logic                  rd_ok;
  logic [31:0]           rd_val;
  logic                  unused_ok;

  assign unused_ok = ^{APB_M_0_paddr[31:8], wdata_q};

  assign start_xfer = APB_M_0_psel & APB_M_0_penable;
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  // Writes take effect on the edge that closes the response cycle.
  assign commit     = (state_q == S_RESP) && write_q && !err_q;

  // State register
  always_ff @(posedge FCLK_CLK1) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state logic; a dropped psel during wait states aborts the transfer.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        wcnt_d = '0;
        if (start_xfer)
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (!APB_M_0_psel)
          state_d = S_IDLE;
        else if (wcnt_q == 2'(WAIT_STATES - 1))
          state_d = S_RESP;
        else
          wcnt_d = wcnt_q + 2'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    APB_M_0_pready  = (state_q == S_RESP);
    APB_M_0_pslverr = (state_q == S_RESP) && err_q;
    APB_M_0_prdata  = (state_q == S_RESP) ? rdata_q : 32'h0;
  end

  // With zero wait states the response is built straight from the bus.
  assign rd_addr  = (state_q == S_IDLE) ? APB_M_0_paddr[7:0] : addr_q;
  assign rd_write = (state_q == S_IDLE) ? APB_M_0_pwrite : write_q;

  always_comb begin
    rd_ok  = 1'b0;
    rd_val = 32'h0;
    if (rd_addr[1:0] == 2'b00) begin
      if (rd_addr == 8'h00) begin
        rd_ok     = 1'b1;
        rd_val[0] = start_q;
        rd_val[1] = irqen_q;
      end
      if (rd_addr == 8'h04) begin
        rd_ok                = 1'b1;
        rd_val[NUM_CH-1:0]   = status_q;
      end
      if (rd_addr == 8'h08) begin
        rd_ok                  = 1'b1;
        rd_val[LENGTH_ADD-1:0] = thresh_q;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_addr == 8'(16 + 4 * i)) begin
          rd_ok                    = 1'b1;
          rd_val[16 +: DATA_SIZE]  = pdat_q[i];
          rd_val[0 +: LENGTH_ADD]  = pcnt_q[i];
        end
      end
    end
  end

  // Transfer capture and response registers
  always_ff @(posedge FCLK_CLK1) begin
    if (!rstn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start_xfer) begin
        addr_q  <= APB_M_0_paddr[7:0];
        wdata_q <= APB_M_0_pwdata;
        write_q <= APB_M_0_pwrite;
      end
      if (enter_resp) begin
        err_q   <= !rd_ok;
        rdata_q <= (rd_ok && !rd_write) ? rd_val : 32'h0;
      end
    end
  end

  // Register file next state
  always_comb begin
    logic [LENGTH_ADD-1:0] cnt_in;
    logic [DATA_SIZE-1:0]  dat_in;
    logic [LENGTH_ADD-1:0] base;
    logic                  clr;
    logic                  upd;
    logic                  st_clr;
    start_d  = start_q;
    irqen_d  = irqen_q;
    thresh_d = thresh_q;
    status_d = status_q;
    cnt_in   = '0;
    dat_in   = '0;
    base     = '0;
    clr      = 1'b0;
    upd      = 1'b0;
    st_clr   = 1'b0;
    if (commit && addr_q == 8'h00) begin
      start_d = wdata_q[0];
      irqen_d = wdata_q[1];
    end
    if (commit && addr_q == 8'h08)
      thresh_d = wdata_q[LENGTH_ADD-1:0];
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_in = ChMaxCount[i*LENGTH_ADD +: LENGTH_ADD];
      dat_in = ChMaxData[i*DATA_SIZE +: DATA_SIZE];
      clr    = commit && (addr_q == 8'(16 + 4 * i));
      // A same-cycle clear means the sample competes against zero.
      base   = clr ? '0 : pcnt_q[i];
      upd    = ChValid[i] && (cnt_in > base);
      st_clr = commit && (addr_q == 8'h04) && wdata_q[i];
      pcnt_d[i] = upd ? cnt_in : base;
      pdat_d[i] = upd ? dat_in : (clr ? '0 : pdat_q[i]);
      status_d[i] = (upd && cnt_in >= thresh_q) |
                    (status_q[i] & ~st_clr);
    end
  end

  always_ff @(posedge FCLK_CLK1) begin
    if (!rstn) begin
      start_q  <= 1'b1;
      irqen_q  <= 1'b0;
      thresh_q <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        pcnt_q[i] <= '0;
        pdat_q[i] <= '0;
      end
    end else begin
      start_q  <= start_d;
      irqen_q  <= irqen_d;
      thresh_q <= thresh_d;
      status_q <= status_d;
      irq_q    <= irqen_q & (|status_q);
      for (int i = 0; i < NUM_CH; i++) begin
        pcnt_q[i] <= pcnt_d[i];
        pdat_q[i] <= pdat_d[i];
      end
    end
  end

  assign StartColl = start_q;
  assign Irq       = irq_q;

endmodule
